// File: rtl/mips_pkg.sv
// Shared constants for the multiply/HI-LO datapath: default operand width,
// FSM state encoding and iteration-counter sizing.
package mips_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int CNT_W = $clog2(WIDTH_DEFAULT);

  // Counter width for an arbitrary operand width (never narrower than 1 bit).
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/multu_step.sv
// One radix-2 shift-add iteration: conditionally add the multiplicand into the
// upper half of the partial product, then shift the whole thing right by one.
module multu_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]  p_i,
  input  logic [WIDTH-1:0]  mcand_i,
  output logic [2*WIDTH:0]  p_o
);

  logic [WIDTH:0] addend;
  logic [WIDTH:0] upper;

  // The upper slice is kept at WIDTH+1 bits so the add carry survives the shift.
  always_comb begin
    addend = p_i[0] ? {1'b0, mcand_i} : '0;
    upper  = p_i[2*WIDTH:WIDTH] + addend;
    p_o    = {1'b0, upper, p_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/multu_hilo_unit.sv
// Iterative unsigned multiplier (one multiplier bit per cycle) owning the
// architectural HI/LO registers, their read port and the pipeline stall request.
module multu_hilo_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mfhi,
  input  logic             mflo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic             stall
);

  localparam int PW = 2*WIDTH + 1;
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    p_q, p_d;
  logic [PW-1:0]    p_step;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             accept;

  multu_step #(.WIDTH(WIDTH)) u_step (
    .p_i     (p_q),
    .mcand_i (mcand_q),
    .p_o     (p_step)
  );

  // A start while iterating is dropped; the stall output makes the issuer hold it.
  assign accept = start && (state_q != ST_RUN);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    p_d     = p_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      ST_RUN: begin
        p_d     = p_step;
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          hi_d    = p_step[2*WIDTH-1:WIDTH];
          lo_d    = p_step[WIDTH-1:0];
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      mcand_d = a;
      p_d     = {{(WIDTH+1){1'b0}}, b};
      count_d = '0;
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      p_q     <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      p_q     <= p_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign hilo_rdata = mfhi ? hi_q : lo_q;
  assign stall      = busy & (mfhi | mflo | start);

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Bench for multu_hilo_unit: directed scenarios plus randomized operands,
// compared against a plain-arithmetic product model.
module tb_multu_hilo_unit;

  localparam int W     = 32;
  localparam int BOUND = 2*W + 8;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         mfhi  = 1'b0;
  logic         mflo  = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, stall;
  logic [W-1:0] hi, lo, hilo_rdata;

  int passed = 0;
  int total  = 0;

  multu_hilo_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
    .mfhi       (mfhi),
    .mflo       (mflo),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .hilo_rdata (hilo_rdata),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] xe, ye;
    xe = {{W{1'b0}}, x};
    ye = {{W{1'b0}}, y};
    return xe * ye;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one multiply and wait for done; edges counts clock edges after the
  // issuing edge until done is seen, or -1 if it never appears.
  task automatic mul_op(input logic [W-1:0] x, input logic [W-1:0] y, output int edges);
    a = x; b = y; start = 1'b1;
    step();
    start = 1'b0;
    edges = 0;
    while (!done && edges < BOUND) begin
      step();
      edges++;
    end
    if (!done) edges = -1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0;
    step(); step();
    reset = 1'b1;
    #1;
    total++;
    if ({busy, done, stall, hi, lo} !== {3'b000, {(2*W){1'b0}}})
      $display("FAIL reset_state: busy/done/stall/hi/lo got %b%b%b %h %h expected 000 0 0", busy, done, stall, hi, lo);
    else passed++;

    reset = 1'b0; start = 1'b1; a = 32'd5; b = 32'd6;
    step();
    reset = 1'b1; start = 1'b0;
    #1;
    total++;
    if ({busy, done} !== 2'b00)
      $display("FAIL reset_start_ignored: busy/done got %b%b expected 00", busy, done);
    else passed++;
    step();
    total++;
    if ({busy, done} !== 2'b00)
      $display("FAIL reset_start_ignored_next: busy/done got %b%b expected 00", busy, done);
    else passed++;
  endtask

  task automatic test_basic();
    int e, bad;
    a = 32'd3; b = 32'd5; start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if ({busy, done, hi, lo} !== {2'b10, {(2*W){1'b0}}})
      $display("FAIL basic_after_issue: busy/done got %b%b hi %h lo %h expected 10 0 0", busy, done, hi, lo);
    else passed++;
    e = 0; bad = 0;
    while (!done && e < BOUND) begin
      if (busy !== 1'b1) bad++;
      step();
      e++;
    end
    total++;
    if (e !== W || bad !== 0)
      $display("FAIL basic_latency: edges %0d busy_gaps %0d expected %0d and 0", e, bad, W);
    else passed++;
    total++;
    if ({busy, done, hi, lo} !== {2'b01, 32'h0000_0000, 32'h0000_000F})
      $display("FAIL basic_result: busy/done %b%b hi %h lo %h expected 01 00000000 0000000f", busy, done, hi, lo);
    else passed++;
    step();
    total++;
    if ({busy, done} !== 2'b00)
      $display("FAIL basic_done_pulse: busy/done got %b%b expected 00", busy, done);
    else passed++;
  endtask

  task automatic test_max_and_idle_read();
    int e;
    mul_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, e);
    total++;
    if (e !== W || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001)
      $display("FAIL max_product: edges %0d hi %h lo %h expected %0d fffffffe 00000001", e, hi, lo, W);
    else passed++;
    step();

    a = 32'd2; b = 32'd3; start = 1'b1; mfhi = 1'b1; mflo = 1'b0;
    #1;
    total++;
    if (stall !== 1'b0 || hilo_rdata !== 32'hFFFF_FFFE)
      $display("FAIL idle_start_mfhi: stall %b rdata %h expected 0 fffffffe", stall, hilo_rdata);
    else passed++;
    mfhi = 1'b0; mflo = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0 || hilo_rdata !== 32'h0000_0001)
      $display("FAIL idle_mflo: stall %b rdata %h expected 0 00000001", stall, hilo_rdata);
    else passed++;
    mfhi = 1'b1;
    #1;
    total++;
    if (hilo_rdata !== 32'hFFFF_FFFE)
      $display("FAIL read_priority: rdata %h expected fffffffe", hilo_rdata);
    else passed++;
    step();
    start = 1'b0; mfhi = 1'b0; mflo = 1'b0;
    e = 0;
    while (!done && e < BOUND) begin
      step();
      e++;
    end
    total++;
    if (e !== W || {hi, lo} !== 64'd6)
      $display("FAIL idle_issue_result: edges %0d hi %h lo %h expected %0d 0 6", e, hi, lo, W);
    else passed++;
    step();
  endtask

  task automatic test_stall_read();
    int e, iter, bad;
    logic [W-1:0] xa, xb;
    logic [2*W-1:0] exp;
    mul_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, e);
    step();
    xa = $urandom; xb = $urandom;
    exp = ref_mul(xa, xb);
    a = xa; b = xb; start = 1'b1;
    step();
    start = 1'b0;
    iter = 0;
    while (iter < 5) begin
      step();
      iter++;
    end
    a = $urandom; b = $urandom; start = 1'b1;
    #1;
    total++;
    if (stall !== 1'b1)
      $display("FAIL stall_on_start: stall %b expected 1", stall);
    else passed++;
    step();
    iter++;
    start = 1'b0; a = '0; b = '0;
    while (iter < 10) begin
      step();
      iter++;
    end
    mfhi = 1'b1;
    #1;
    bad = 0;
    while (busy && iter < BOUND) begin
      if (stall !== 1'b1 || hilo_rdata !== 32'hFFFF_FFFE) bad++;
      step();
      iter++;
    end
    total++;
    if (bad !== 0 || iter !== W)
      $display("FAIL stall_mfhi_run: bad_cycles %0d edges %0d expected 0 %0d", bad, iter, W);
    else passed++;
    total++;
    if (done !== 1'b1 || stall !== 1'b0 || hilo_rdata !== exp[2*W-1:W] || lo !== exp[W-1:0])
      $display("FAIL stall_done_read: done %b stall %b rdata %h lo %h expected 1 0 %h %h",
               done, stall, hilo_rdata, lo, exp[2*W-1:W], exp[W-1:0]);
    else passed++;
    mfhi = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int e;
    logic [W-1:0] x1, y1;
    logic [2*W-1:0] exp1;
    x1 = $urandom; y1 = $urandom;
    exp1 = ref_mul(x1, y1);
    mul_op(x1, y1, e);
    total++;
    if (e !== W || {hi, lo} !== exp1)
      $display("FAIL b2b_first: edges %0d hi:lo %h expected %0d %h", e, {hi, lo}, W, exp1);
    else passed++;
    a = 32'h0001_0000; b = 32'h0001_0000; start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if ({busy, done} !== 2'b10 || {hi, lo} !== exp1)
      $display("FAIL b2b_accept: busy/done %b%b hi:lo %h expected 10 %h", busy, done, {hi, lo}, exp1);
    else passed++;
    e = 0;
    while (!done && e < BOUND) begin
      step();
      e++;
    end
    total++;
    if (e !== W || hi !== 32'h0000_0001 || lo !== 32'h0000_0000)
      $display("FAIL b2b_second: edges %0d hi %h lo %h expected %0d 00000001 00000000", e, hi, lo, W);
    else passed++;
  endtask

  task automatic test_abort();
    int e, bad;
    a = 32'd7; b = 32'd9; start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    total++;
    if ({busy, done, hi, lo} !== {2'b00, {(2*W){1'b0}}})
      $display("FAIL abort_state: busy/done %b%b hi %h lo %h expected 00 0 0", busy, done, hi, lo);
    else passed++;
    bad = 0;
    repeat (W + 4) begin
      if (done !== 1'b0 || busy !== 1'b0) bad++;
      step();
    end
    total++;
    if (bad !== 0)
      $display("FAIL abort_no_done: active_cycles %0d expected 0", bad);
    else passed++;
    mul_op(32'd7, 32'd9, e);
    total++;
    if (e !== W || hi !== 32'h0 || lo !== 32'h0000_003F)
      $display("FAIL abort_rerun: edges %0d hi %h lo %h expected %0d 0 0000003f", e, hi, lo, W);
    else passed++;
    step();
  endtask

  task automatic test_random();
    int e;
    logic [W-1:0] x, y;
    logic [2*W-1:0] exp;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: x = '0;
        1: x = '1;
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: y = '0;
        1: y = '1;
        default: y = $urandom;
      endcase
      exp = ref_mul(x, y);
      mul_op(x, y, e);
      total++;
      if (e !== W || {hi, lo} !== exp)
        $display("FAIL random_%0d: a %h b %h edges %0d hi:lo %h expected %0d %h", i, x, y, e, {hi, lo}, W, exp);
      else passed++;
      if ($urandom_range(0, 1) == 1) step();
    end
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_max_and_idle_read();
    test_stall_read();
    test_back_to_back();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
